ram_picture_frame: RTL and testbench
====================================

# ram_picture_frame

Single-port synchronous frame buffer that stores one camera frame byte-by-byte and reports when the frame is full. It sits between the camera capture logic (which supplies pixel bytes, write enable and a pixel address) and any downstream reader that fetches stored bytes by address. A sticky `fin` flag blocks further writes once the last location has been written, so the capture logic can stop.

## Interface
- `ADDR_W`, 19: address width in bits.
- `DATA_W`, 8: data byte width in bits.
- `DEPTH`, 307200: number of stored locations (640×480). Must satisfy `DEPTH <= 2**ADDR_W`.
- `clk_i`  in  1  single clock; all sampling on rising edge (driven by camera PCLK).
- `rst`  in  1  asynchronous, active-low reset.
- `we_i`  in  1  write request.
- `re_i`  in  1  read request.
- `adr_i`  in  ADDR_W  location for the read or write.
- `dat_i`  in  DATA_W  write data.
- `dat_o`  out  DATA_W  registered read data.
- `fin`  out  1  frame-full flag, sticky.

## Operation
- Effective write: `we_i & ~fin & (adr_i < DEPTH)`. It stores `dat_i` at `adr_i` on the rising edge.
- A write with `adr_i >= DEPTH` is dropped silently and has no effect on `fin`.
- `fin` sets on the edge that performs an effective write to address `DEPTH-1`. It stays set until reset; no other event clears it, except the configuration option below.
- While `fin` = 1, all writes are ignored. Reads continue to work.
- Read: when `re_i` = 1 and no effective write occurs in the same cycle, `dat_o` loads `mem[adr_i]`. If `adr_i >= DEPTH`, `dat_o` loads 0.
- Simultaneous `we_i` and `re_i`: an effective write takes priority and `dat_o` holds its value. If the write is blocked (because of `fin` or an out-of-range address), the read proceeds.
- `dat_o` holds its last value whenever no read is performed.
- Memory contents are not cleared by reset. A read of a location not yet written returns an undefined value.

## Timing
- Reset (`rst` = 0, asynchronous): `dat_o` = 0, `fin` = 0 immediately. Memory is untouched.
- Write latency: data is visible to a read issued in the following cycle. A read on the cycle after a write to the same address returns the new data.
- Read latency: 1 cycle. `dat_o` is valid after the rising edge that sampled `re_i` = 1.
- `fin` rises 1 cycle after the edge that samples the write to `DEPTH-1`, i.e. it is registered.
- Reset asserted mid-frame: `fin` and `dat_o` clear. After release, writes resume from whatever address the requester presents.
- After `rst` is released, the first edge is a normal operating edge.

## Configuration
- `RAM_PICTURE_FRAME_REARM_EN`
  - Defined: adds input port `rearm_i` (1 bit). When `rearm_i` = 1 on a rising edge, `fin` clears to 0 and that same cycle's write is suppressed, so a new frame can be captured without reset. `rearm_i` has priority over a `fin`-setting write in the same cycle.
  - Undefined: no `rearm_i` port. `fin` clears only on reset.

## Structure
- Shared package `ram_picture_frame_pkg`: `ADDR_W`, `DATA_W`, `DEPTH` defaults as localparams/constants, plus the 640×480 frame geometry constants `FRAME_W` = 640 and `FRAME_H` = 480.
- One sub-module, `frame_ram_sp`:
  - Inferable single-port synchronous RAM with write enable, registered read and read enable.
  - Ports: clock, we, re, addr, din, dout. No reset on the array.
- The top level holds the address-range check, the `fin` flag logic, write/read arbitration and zeroing of out-of-range reads.

## Test plan
- Reset: hold `rst` = 0 with random `we_i`/`re_i`; release → `dat_o` = 0 and `fin` = 0 throughout reset.
- Write/read back: write 0xA5 @0, 0x3C @1, 0xFF @100; then read 0, 1, 100 → `dat_o` = 0xA5, 0x3C, 0xFF, each 1 cycle after `re_i`.
- Frame full: write 0x11 @306, 0x77 @307199 → `fin` = 1 one cycle later. Then write 0x22 @306 and read 306 → `dat_o` = 0x11, and `fin` stays 1.
- Out of range: write 0x55 @307200 → `fin` stays 0. Read 307200 → `dat_o` = 0x00.
- Collision: with `fin` = 0, `we_i` = `re_i` = 1 @5 with `dat_i` = 0x9C while `dat_o` = 0x3C → `dat_o` stays 0x3C. A read of 5 on the next cycle gives 0x9C.
- Async reset mid-frame: set `fin`, then pulse `rst` low between clock edges → `fin` and `dat_o` drop to 0 without waiting for a clock edge. A later write @0 of 0x42 followed by a read returns 0x42.

Source files
------------

// File: rtl/ram_picture_frame_pkg.sv
// Shared constants for the picture frame buffer: bus widths, depth and the
// 640x480 frame geometry the default depth is derived from.
package ram_picture_frame_pkg;

    localparam int unsigned FRAME_W = 640;
    localparam int unsigned FRAME_H = 480;

    localparam int unsigned ADDR_W  = 19;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned DEPTH   = FRAME_W * FRAME_H;

    typedef logic [DATA_W-1:0] pixel_t;
    typedef logic [ADDR_W-1:0] pix_adr_t;

endpackage

// File: rtl/frame_ram_sp.sv
// Inferable single-port synchronous RAM: write enable, read enable and a
// registered read port. The array is never reset.
module frame_ram_sp #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 307200
) (
    input  logic              clk_i,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dout;

    // Write port plus registered read; read output holds when re is low.
    always_ff @(posedge clk_i) begin
        if (we) begin
            r_mem[addr] <= din;
        end
        if (re) begin
            r_dout <= r_mem[addr];
        end
    end

    assign dout = r_dout;

endmodule

// File: rtl/ram_picture_frame.sv
// Single-port frame buffer with a sticky frame-full flag.
// Optional feature macro: RAM_PICTURE_FRAME_REARM_EN adds rearm_i, which
// clears fin and suppresses that cycle's write so a new frame can start.
module ram_picture_frame
    import ram_picture_frame_pkg::*;
#(
    parameter int unsigned ADDR_W = ram_picture_frame_pkg::ADDR_W,
    parameter int unsigned DATA_W = ram_picture_frame_pkg::DATA_W,
    parameter int unsigned DEPTH  = ram_picture_frame_pkg::DEPTH
) (
    input  logic              clk_i,
    input  logic              rst,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic [DATA_W-1:0] dat_i,
`ifdef RAM_PICTURE_FRAME_REARM_EN
    input  logic              rearm_i,
`endif
    output logic [DATA_W-1:0] dat_o,
    output logic              fin
);

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   DepthW  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LastAdr = ADDR_W'(DEPTH - 1);

    logic              w_in_range;
    logic              w_rearm;
    logic              w_wr_eff;
    logic              w_rd_eff;
    logic [DATA_W-1:0] w_ram_dout;
    logic              r_fin;
    logic              r_zero;

`ifdef RAM_PICTURE_FRAME_REARM_EN
    assign w_rearm = rearm_i;
`else
    assign w_rearm = 1'b0;
`endif

    assign w_in_range = ({1'b0, adr_i} < DepthW);
    assign w_wr_eff   = we_i & ~r_fin & w_in_range & ~w_rearm;
    assign w_rd_eff   = re_i & ~w_wr_eff;

    frame_ram_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i  (clk_i),
        .we     (w_wr_eff),
        .re     (w_rd_eff & w_in_range),
        .addr   (adr_i),
        .din    (dat_i),
        .dout   (w_ram_dout)
    );

    // Sticky frame-full flag: set by the write to the last location.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            r_fin <= 1'b0;
        end else if (w_rearm) begin
            r_fin <= 1'b0;
        end else if (w_wr_eff && (adr_i == LastAdr)) begin
            r_fin <= 1'b1;
        end
    end

    // Forces dat_o to zero after reset or an out-of-range read, since the
    // RAM output register itself has no reset.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            r_zero <= 1'b1;
        end else if (w_rd_eff) begin
            r_zero <= ~w_in_range;
        end
    end

    assign dat_o = r_zero ? '0 : w_ram_dout;
    assign fin   = r_fin;

endmodule

// File: tb/tb_ram_picture_frame.sv
// Self-checking bench for ram_picture_frame: directed vector table, hand
// sequences for reset corners, then random traffic against a byte-map model.
module tb_ram_picture_frame;
    import ram_picture_frame_pkg::*;

    logic              clk_i = 1'b0;
    logic              rst   = 1'b0;
    logic              we_i  = 1'b0;
    logic              re_i  = 1'b0;
    logic [ADDR_W-1:0] adr_i = '0;
    logic [DATA_W-1:0] dat_i = '0;
    logic [DATA_W-1:0] dat_o;
    logic              fin;
`ifdef RAM_PICTURE_FRAME_REARM_EN
    logic              rearm_i = 1'b0;
`endif

    int n_chk = 0;
    int n_err = 0;

    // Reference model: sparse byte map plus expected output state.
    logic [7:0] m_mem [int];
    bit         m_fin;
    logic [7:0] m_dat;
    bit         m_known;

    ram_picture_frame dut (
        .clk_i  (clk_i),
        .rst    (rst),
        .we_i   (we_i),
        .re_i   (re_i),
        .adr_i  (adr_i),
        .dat_i  (dat_i),
`ifdef RAM_PICTURE_FRAME_REARM_EN
        .rearm_i(rearm_i),
`endif
        .dat_o  (dat_o),
        .fin    (fin)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit         we;
        bit         re;
        int         adr;
        logic [7:0] dat;
        logic [7:0] exp_dat;
        bit         exp_fin;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle; inputs change 1 time unit after the rising edge.
    task automatic drive_edge(input bit we, input bit re, input int adr, input logic [7:0] dat);
        we_i  = we;
        re_i  = re;
        adr_i = ADDR_W'(adr);
        dat_i = dat;
        @(posedge clk_i);
        #1;
    endtask

    // Model a functional edge according to the behavioural rules.
    task automatic model_edge(input bit we, input bit re, input int adr, input logic [7:0] dat);
        bit wr;
        wr = we && !m_fin && (adr < int'(DEPTH));
        if (wr) begin
            m_mem[adr] = dat;
            if (adr == int'(DEPTH) - 1) m_fin = 1'b1;
        end else if (re) begin
            if (adr >= int'(DEPTH)) begin
                m_dat   = 8'h00;
                m_known = 1'b1;
            end else if (m_mem.exists(adr)) begin
                m_dat   = m_mem[adr];
                m_known = 1'b1;
            end else begin
                m_known = 1'b0;
            end
        end
    endtask

    task automatic model_step(input bit we, input bit re, input int adr, input logic [7:0] dat);
        model_edge(we, re, adr, dat);
        drive_edge(we, re, adr, dat);
        if (m_known) check("rand_dat", 32'(dat_o), 32'(m_dat));
        check("rand_fin", 32'(fin), 32'(m_fin));
    endtask

    task automatic async_reset_pulse();
        @(posedge clk_i);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_fin", 32'(fin), 32'd0);
        check("async_rst_dat", 32'(dat_o), 32'd0);
        #2;
        rst = 1'b1;
        m_fin   = 1'b0;
        m_dat   = 8'h00;
        m_known = 1'b1;
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        int   adr;

        // Reset held with random request activity.
        for (int i = 0; i < 5; i++) begin
            drive_edge(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                       int'($urandom_range(0, 200)), 8'($urandom));
            check("reset_dat", 32'(dat_o), 32'd0);
            check("reset_fin", 32'(fin), 32'd0);
        end
        we_i = 1'b0;
        re_i = 1'b0;
        #3;
        rst = 1'b1;
        check("release_dat", 32'(dat_o), 32'd0);
        check("release_fin", 32'(fin), 32'd0);

        // {we, re, adr, dat, expected dat_o, expected fin} after each edge.
        vecs.push_back('{1, 0, 0,      8'hA5, 8'h00, 0});
        vecs.push_back('{1, 0, 1,      8'h3C, 8'h00, 0});
        vecs.push_back('{1, 0, 100,    8'hFF, 8'h00, 0});
        vecs.push_back('{0, 1, 0,      8'h00, 8'hA5, 0});
        vecs.push_back('{0, 1, 100,    8'h00, 8'hFF, 0});
        vecs.push_back('{0, 1, 1,      8'h00, 8'h3C, 0});
        vecs.push_back('{1, 1, 5,      8'h9C, 8'h3C, 0});
        vecs.push_back('{0, 1, 5,      8'h00, 8'h9C, 0});
        vecs.push_back('{1, 0, 307200, 8'h55, 8'h9C, 0});
        vecs.push_back('{0, 1, 307200, 8'h00, 8'h00, 0});
        vecs.push_back('{1, 1, 307201, 8'h66, 8'h00, 0});
        vecs.push_back('{0, 1, 5,      8'h00, 8'h9C, 0});
        vecs.push_back('{1, 0, 306,    8'h11, 8'h9C, 0});
        vecs.push_back('{1, 0, 307199, 8'h77, 8'h9C, 1});
        vecs.push_back('{1, 0, 306,    8'h22, 8'h9C, 1});
        vecs.push_back('{0, 1, 306,    8'h00, 8'h11, 1});
        vecs.push_back('{1, 1, 0,      8'h33, 8'hA5, 1});
        vecs.push_back('{0, 1, 307199, 8'h00, 8'h77, 1});
        vecs.push_back('{0, 0, 1,      8'h00, 8'h77, 1});

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive_edge(v.we, v.re, v.adr, v.dat);
            check($sformatf("vec%0d_dat", i), 32'(dat_o), 32'(v.exp_dat));
            check($sformatf("vec%0d_fin", i), 32'(fin), 32'(v.exp_fin));
        end

        // fin is set here; an asynchronous pulse must clear it immediately.
        re_i = 1'b0;
        we_i = 1'b0;
        async_reset_pulse();
        drive_edge(1, 0, 0, 8'h42);
        check("post_rst_wr_fin", 32'(fin), 32'd0);
        drive_edge(0, 1, 0, 8'h00);
        check("post_rst_rd", 32'(dat_o), 32'h42);

        // Seed the model with what the directed phase left in memory.
        m_mem[0]      = 8'h42;
        m_mem[1]      = 8'h3C;
        m_mem[5]      = 8'h9C;
        m_mem[100]    = 8'hFF;
        m_mem[306]    = 8'h11;
        m_mem[307199] = 8'h77;
        m_fin   = 1'b0;
        m_dat   = 8'h42;
        m_known = 1'b1;

        for (int i = 0; i < 800; i++) begin
            if (i % 150 == 149) async_reset_pulse();
            case ($urandom_range(0, 3))
                0, 1:    adr = int'($urandom_range(0, 31));
                2:       adr = int'(DEPTH) - 4 + int'($urandom_range(0, 7));
                default: adr = int'($urandom_range(0, (1 << ADDR_W) - 1));
            endcase
            model_step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), adr, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
